layer_sequencer: RTL

//  Top-level schedule controller for the 5-layer LeNet flow (CONV1, CONV2, FC1, FC2, FC3) on the shared ROWSxCOLS systolic array.

---
 rtl/layer_sequencer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
//   Schedule controller for the five-layer LeNet flow (CONV1, CONV2, FC1, FC2,
//   FC3) running on the shared systolic array. For each layer it:
//   - loads the per-layer ROM enables, feature-RAM read/write enables and
//     geometry;
//   - pulses core_start once;
//   - waits for core_done;
//   - holds everything for a drain window so the array can flush its
//     writeback, then moves on to the next layer.
//   A watchdog aborts into a sticky error state if the core never answers.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   start         run request (debounced key), rising edge detected here
//   init_done     image RAM loaded (level)
//   core_done     one-cycle pulse from the core: current layer written
//   core_start    one-cycle pulse: begin current layer
//   layer_index   1..NUM_LAYERS while sequencing, 0 when idle/done/error
//   clk_en        one-hot weight/bias ROM enable, bit k-1 = layer k
//   mem_en        {wr_fc2,rd_fc2,wr_fc1,rd_fc1,wr_out2,rd_out2,wr_out1,rd_out1,rd_img}
//   kernel_dim, kernel_num, stride, infmap_rows   current layer geometry
//   busy          high while configuring, running or draining a layer
//   done          schedule finished, held until the next start edge
//   err           sticky watchdog flag, cleared by reset or a start edge
// -----------------------------------------------------------------------------
module layer_sequencer #(
  parameter int NUM_LAYERS = 5,
  parameter int DRAIN_CYC  = 8,
  parameter int TO_W       = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        init_done,
  input  logic        core_done,
  output logic        core_start,
  output logic [3:0]  layer_index,
  output logic [4:0]  clk_en,
  output logic [8:0]  mem_en,
  output logic [3:0]  kernel_dim,
  output logic [15:0] kernel_num,
  output logic [1:0]  stride,
  output logic [5:0]  infmap_rows,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_INIT,
    S_CFG,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  typedef struct packed {
    logic [4:0]  clk_en;
    logic [8:0]  mem_en;
    logic [3:0]  dim;
    logic [15:0] num;
    logic [1:0]  stride;
    logic [5:0]  rows;
  } cfg_t;

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN_CYC - 1);
  localparam logic [DW-1:0]   DRAIN_ONE  = DW'(1);
  // Leaving RUN when the counter reads all-ones minus one gives exactly
  // 2^TO_W-1 RUN cycles before the abort.
  localparam logic [TO_W-1:0] WD_LAST    = {{(TO_W-1){1'b1}}, 1'b0};
  localparam logic [TO_W-1:0] WD_ONE     = TO_W'(1);
  localparam logic [3:0]      LAST_LAYER = 4'(NUM_LAYERS);

  // Layer table. mem_en bit order:
  //   8 wr_fc2, 7 rd_fc2, 6 wr_fc1, 5 rd_fc1, 4 wr_out2,
  //   3 rd_out2, 2 wr_out1, 1 rd_out1, 0 rd_img.
  // Layer 5 writes back into the FC1 buffer, which is free by then.
  function automatic cfg_t layer_cfg(input logic [3:0] l);
    cfg_t c;
    c = '0;
    case (l)
      4'd1: begin
        c.clk_en = 5'b00001; c.mem_en = 9'b000000101;
        c.dim = 4'd5; c.num = 16'd6;   c.stride = 2'd1; c.rows = 6'd32;
      end
      4'd2: begin
        c.clk_en = 5'b00010; c.mem_en = 9'b000010010;
        c.dim = 4'd5; c.num = 16'd16;  c.stride = 2'd1; c.rows = 6'd14;
      end
      4'd3: begin
        c.clk_en = 5'b00100; c.mem_en = 9'b001001000;
        c.dim = 4'd5; c.num = 16'd120; c.stride = 2'd1; c.rows = 6'd5;
      end
      4'd4: begin
        c.clk_en = 5'b01000; c.mem_en = 9'b100100000;
        c.dim = 4'd1; c.num = 16'd84;  c.stride = 2'd1; c.rows = 6'd1;
      end
      4'd5: begin
        c.clk_en = 5'b10000; c.mem_en = 9'b011000000;
        c.dim = 4'd1; c.num = 16'd10;  c.stride = 2'd1; c.rows = 6'd1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t          state_q;
  logic            start_dly_q;
  logic            core_start_q;
  logic [3:0]      layer_q;
  cfg_t            cfg_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic [TO_W-1:0] wdog_q;
  logic [DW-1:0]   drain_q;
  logic            start_edge;

  assign start_edge = start & ~start_dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      start_dly_q  <= 1'b0;
      core_start_q <= 1'b0;
      layer_q      <= 4'd0;
      cfg_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      wdog_q       <= '0;
      drain_q      <= '0;
    end else begin
      start_dly_q  <= start;
      core_start_q <= 1'b0;
      case (state_q)
        // Only a fresh edge restarts; a start held across DONE does not.
        S_IDLE, S_DONE, S_ERR: begin
          if (start_edge) begin
            state_q <= S_WAIT_INIT;
            layer_q <= 4'd1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        S_WAIT_INIT: begin
          if (init_done) begin
            state_q <= S_CFG;
            cfg_q   <= layer_cfg(layer_q);
            busy_q  <= 1'b1;
          end
        end
        S_CFG: begin
          state_q      <= S_RUN;
          core_start_q <= 1'b1;
          wdog_q       <= '0;
        end
        // core_done wins over a simultaneous watchdog expiry.
        S_RUN: begin
          if (core_done) begin
            state_q <= S_DRAIN;
            wdog_q  <= '0;
            drain_q <= '0;
          end else if (wdog_q == WD_LAST) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            layer_q <= 4'd0;
            cfg_q   <= '0;
          end else begin
            wdog_q <= wdog_q + WD_ONE;
          end
        end
        S_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            if (layer_q < LAST_LAYER) begin
              state_q <= S_CFG;
              layer_q <= layer_q + 4'd1;
              cfg_q   <= layer_cfg(layer_q + 4'd1);
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              layer_q <= 4'd0;
              cfg_q   <= '0;
            end
          end else begin
            drain_q <= drain_q + DRAIN_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_start  = core_start_q;
  assign layer_index = layer_q;
  assign clk_en      = cfg_q.clk_en;
  assign mem_en      = cfg_q.mem_en;
  assign kernel_dim  = cfg_q.dim;
  assign kernel_num  = cfg_q.num;
  assign stride      = cfg_q.stride;
  assign infmap_rows = cfg_q.rows;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
